// File: rtl/dog_sprite_fetch_if.sv
// Scan/ROM/palette bundle for the dog sprite fetch stage.
// Optional mirror input is present only with DOG_MIRROR_EN defined.
interface dog_sprite_fetch_if #(
    parameter int ROM_ADDR_W = 11
);
    logic [9:0]            DrawX;
    logic [9:0]            DrawY;
    logic                  frame_start;
    logic [9:0]            dog_x;
    logic [9:0]            dog_y;
    logic                  anim_en;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [3:0]            rom_q;
    logic [3:0]            palette_index;
    logic                  pixel_on;
`ifdef DOG_MIRROR_EN
    logic                  mirror;

    modport master (
        output DrawX, DrawY, frame_start, dog_x, dog_y, anim_en,
        output rom_q, mirror,
        input  rom_addr, palette_index, pixel_on
    );

    modport slave (
        input  DrawX, DrawY, frame_start, dog_x, dog_y, anim_en,
        input  rom_q, mirror,
        output rom_addr, palette_index, pixel_on
    );
`else
    modport master (
        output DrawX, DrawY, frame_start, dog_x, dog_y, anim_en,
        output rom_q,
        input  rom_addr, palette_index, pixel_on
    );

    modport slave (
        input  DrawX, DrawY, frame_start, dog_x, dog_y, anim_en,
        input  rom_q,
        output rom_addr, palette_index, pixel_on
    );
`endif
endinterface

// File: rtl/dog_sprite_fetch.sv
// Dog sprite fetch: scan position -> sprite ROM address -> palette index, 3-clock pipe.
// Define DOG_MIRROR_EN to add a horizontal mirror input sampled in stage 1.
module dog_sprite_fetch #(
    parameter int         SPRITE_W        = 32,
    parameter int         SPRITE_H        = 32,
    parameter int         NUM_FRAMES      = 2,
    parameter int         FRAME_TICKS     = 8,
    parameter int         ROM_ADDR_W      = 11,
    parameter logic [3:0] TRANSPARENT_IDX = 4'd1
) (
    input logic             Clk,
    input logic             Reset,
    dog_sprite_fetch_if.slave bus
);
    localparam int FW  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int TW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int PIX = SPRITE_W * SPRITE_H;

    logic [9:0]            pos_x;
    logic [9:0]            pos_y;
    logic [TW-1:0]         tick_cnt;
    logic [FW-1:0]         anim_frame;
    logic [10:0]           dx;
    logic [10:0]           dy;
    logic [10:0]           col;
    logic                  hit;
    logic                  hit1;
    logic                  hit2;
    logic [31:0]           addr_full;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [3:0]            palette_index;
    logic                  pixel_on;

    // Latch the sprite position only at vblank so a frame never tears.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (bus.frame_start) begin
            pos_x <= bus.dog_x;
            pos_y <= bus.dog_y;
        end
    end

    // Step the animation every FRAME_TICKS enabled vblank pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_cnt   <= '0;
            anim_frame <= '0;
        end else if (bus.frame_start && bus.anim_en) begin
            if (tick_cnt == TW'(FRAME_TICKS - 1)) begin
                tick_cnt <= '0;
                if (anim_frame == FW'(NUM_FRAMES - 1))
                    anim_frame <= '0;
                else
                    anim_frame <= anim_frame + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Sprite-relative offsets; the unsigned-borrow bit flags "left of / above".
    always_comb begin
        dx  = {1'b0, bus.DrawX} - {1'b0, pos_x};
        dy  = {1'b0, bus.DrawY} - {1'b0, pos_y};
        hit = !dx[10] && (dx < 11'(SPRITE_W))
           && !dy[10] && (dy < 11'(SPRITE_H));
`ifdef DOG_MIRROR_EN
        col = bus.mirror ? (11'(SPRITE_W - 1) - dx) : dx;
`else
        col = dx;
`endif
        addr_full = 32'(anim_frame) * 32'(PIX)
                  + 32'(dy) * 32'(SPRITE_W)
                  + 32'(col);
    end

    // Stage 1: register ROM address; misses park the address at 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
        end else begin
            rom_addr <= hit ? addr_full[ROM_ADDR_W-1:0] : '0;
            hit1     <= hit;
        end
    end

    // Stage 2: ROM access cycle, carry the hit flag alongside.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            hit2 <= 1'b0;
        else
            hit2 <= hit1;
    end

    // Stage 3: resolve transparency and register the palette outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            palette_index <= '0;
            pixel_on      <= 1'b0;
        end else begin
            palette_index <= hit2 ? bus.rom_q : TRANSPARENT_IDX;
            pixel_on      <= hit2 && (bus.rom_q != TRANSPARENT_IDX);
        end
    end

    assign bus.rom_addr      = rom_addr;
    assign bus.palette_index = palette_index;
    assign bus.pixel_on      = pixel_on;
endmodule
